// File: rtl/req_ack_window_checker.sv
// Multi-channel monitor for "req |-> ##[MIN_LAT:MAX_LAT] ack" with registered
// pass/fail pulses, saturating pass/fail/vacuous counters and a sticky error flag.
module req_ack_window_checker #(
    parameter int unsigned NUM_CH  = 2,
    parameter int unsigned MIN_LAT = 0,
    parameter int unsigned MAX_LAT = 0,
    parameter int unsigned CNT_W   = 16,
    localparam int unsigned ChW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic [NUM_CH-1:0] req,
    input  logic [NUM_CH-1:0] ack,
    output logic [NUM_CH-1:0] pass_pulse,
    output logic [NUM_CH-1:0] fail_pulse,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  fail_cnt,
    output logic [CNT_W-1:0]  vac_cnt,
    output logic              err_sticky,
    output logic [ChW-1:0]    first_fail_ch
);

    localparam int unsigned OffW = (MAX_LAT > 0) ? $clog2(MAX_LAT + 1) : 1;
    localparam int unsigned PopW = $clog2(NUM_CH + 1);
    localparam int unsigned SumW = CNT_W + PopW;
    localparam int MinLatI = int'(MIN_LAT);
    localparam logic [OffW-1:0] MaxOff = OffW'(MAX_LAT);

    if (MAX_LAT < MIN_LAT) begin : g_bad_lat
        $error("req_ack_window_checker: MAX_LAT must be >= MIN_LAT");
    end
    if (NUM_CH < 1 || NUM_CH > 32) begin : g_bad_ch
        $error("req_ack_window_checker: NUM_CH must be in 1..32");
    end

    typedef enum logic {StIdle, StWait} state_e;

    state_e            state_q [NUM_CH];
    state_e            state_d [NUM_CH];
    logic [OffW-1:0]   off_q   [NUM_CH];
    logic [OffW-1:0]   off_d   [NUM_CH];
    logic [NUM_CH-1:0] pass_dec, fail_dec, vac_dec;
    logic [NUM_CH-1:0] pass_pulse_q, pass_pulse_d, fail_pulse_q, fail_pulse_d;
    logic [CNT_W-1:0]  pass_cnt_q, pass_cnt_d, fail_cnt_q, fail_cnt_d, vac_cnt_q, vac_cnt_d;
    logic              err_sticky_q, err_sticky_d;
    logic [ChW-1:0]    first_fail_ch_q, first_fail_ch_d;

    function automatic logic [PopW-1:0] popcount(input logic [NUM_CH-1:0] v);
        logic [PopW-1:0] n;
        n = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            n = n + PopW'(v[i]);
        end
        return n;
    endfunction

    // Widened add so an overflow into the upper bits clamps instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cur,
                                                 input logic [PopW-1:0]  inc);
        logic [SumW-1:0] sum;
        sum = {{PopW{1'b0}}, cur} + {{CNT_W{1'b0}}, inc};
        if (|sum[SumW-1:CNT_W]) begin
            return {CNT_W{1'b1}};
        end
        return sum[CNT_W-1:0];
    endfunction

    always_comb begin
        pass_dec = '0;
        fail_dec = '0;
        vac_dec  = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            state_d[c] = state_q[c];
            off_d[c]   = off_q[c];
            if (!en) begin
                state_d[c] = StIdle;
                off_d[c]   = '0;
            end else begin
                unique case (state_q[c])
                    StIdle: begin
                        if (!req[c]) begin
                            vac_dec[c] = 1'b1;
                        end else if (MIN_LAT == 0 && ack[c]) begin
                            pass_dec[c] = 1'b1;
                        end else if (MAX_LAT == 0) begin
                            fail_dec[c] = 1'b1;
                        end else begin
                            state_d[c] = StWait;
                            off_d[c]   = OffW'(1);
                        end
                    end
                    StWait: begin
                        if (ack[c]) begin
                            if (int'(off_q[c]) >= MinLatI) pass_dec[c] = 1'b1;
                            else                           fail_dec[c] = 1'b1;
                            state_d[c] = StIdle;
                            off_d[c]   = '0;
                        end else if (off_q[c] == MaxOff) begin
                            fail_dec[c] = 1'b1;
                            state_d[c]  = StIdle;
                            off_d[c]    = '0;
                        end else begin
                            off_d[c] = off_q[c] + OffW'(1);
                        end
                    end
                    default: state_d[c] = StIdle;
                endcase
            end
        end
    end

    always_comb begin
        pass_pulse_d    = pass_dec;
        fail_pulse_d    = fail_dec;
        pass_cnt_d      = sat_add(pass_cnt_q, popcount(pass_dec));
        fail_cnt_d      = sat_add(fail_cnt_q, popcount(fail_dec));
        vac_cnt_d       = sat_add(vac_cnt_q, popcount(vac_dec));
        err_sticky_d    = err_sticky_q;
        first_fail_ch_d = first_fail_ch_q;
        if (!err_sticky_q && |fail_dec) begin
            err_sticky_d = 1'b1;
            // Descending scan leaves the lowest failing index.
            for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
                if (fail_dec[i]) first_fail_ch_d = ChW'(i);
            end
        end
        if (clr) begin
            pass_cnt_d      = '0;
            fail_cnt_d      = '0;
            vac_cnt_d       = '0;
            err_sticky_d    = 1'b0;
            first_fail_ch_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                state_q[i] <= StIdle;
                off_q[i]   <= '0;
            end
            pass_pulse_q    <= '0;
            fail_pulse_q    <= '0;
            pass_cnt_q      <= '0;
            fail_cnt_q      <= '0;
            vac_cnt_q       <= '0;
            err_sticky_q    <= 1'b0;
            first_fail_ch_q <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                state_q[i] <= state_d[i];
                off_q[i]   <= off_d[i];
            end
            pass_pulse_q    <= pass_pulse_d;
            fail_pulse_q    <= fail_pulse_d;
            pass_cnt_q      <= pass_cnt_d;
            fail_cnt_q      <= fail_cnt_d;
            vac_cnt_q       <= vac_cnt_d;
            err_sticky_q    <= err_sticky_d;
            first_fail_ch_q <= first_fail_ch_d;
        end
    end

    assign pass_pulse    = pass_pulse_q;
    assign fail_pulse    = fail_pulse_q;
    assign pass_cnt      = pass_cnt_q;
    assign fail_cnt      = fail_cnt_q;
    assign vac_cnt       = vac_cnt_q;
    assign err_sticky    = err_sticky_q;
    assign first_fail_ch = first_fail_ch_q;

endmodule

// File: tb/tb_req_ack_window_checker.sv
// Directed bench for req_ack_window_checker: four instances cover the default,
// windowed, early-ack and narrow-counter configurations.
module tb_req_ack_window_checker;

    logic clk, rst, en, clr;
    logic [1:0] r0, a0, r1, a1, r2, a2, r3, a3;

    logic [1:0]  pp0, fp0, pp1, fp1, pp2, fp2, pp3, fp3;
    logic [15:0] pc0, fc0, vc0, pc1, fc1, vc1, pc2, fc2, vc2;
    logic [2:0]  pc3, fc3, vc3;
    logic        es0, es1, es2, es3;
    logic        ff0, ff1, ff2, ff3;

    int n_checks = 0;
    int n_errors = 0;

    req_ack_window_checker #(.NUM_CH(2), .MIN_LAT(0), .MAX_LAT(0), .CNT_W(16)) u_dflt (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .req(r0), .ack(a0),
        .pass_pulse(pp0), .fail_pulse(fp0), .pass_cnt(pc0), .fail_cnt(fc0),
        .vac_cnt(vc0), .err_sticky(es0), .first_fail_ch(ff0)
    );
    req_ack_window_checker #(.NUM_CH(2), .MIN_LAT(1), .MAX_LAT(3), .CNT_W(16)) u_w13 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .req(r1), .ack(a1),
        .pass_pulse(pp1), .fail_pulse(fp1), .pass_cnt(pc1), .fail_cnt(fc1),
        .vac_cnt(vc1), .err_sticky(es1), .first_fail_ch(ff1)
    );
    req_ack_window_checker #(.NUM_CH(2), .MIN_LAT(2), .MAX_LAT(3), .CNT_W(16)) u_w23 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .req(r2), .ack(a2),
        .pass_pulse(pp2), .fail_pulse(fp2), .pass_cnt(pc2), .fail_cnt(fc2),
        .vac_cnt(vc2), .err_sticky(es2), .first_fail_ch(ff2)
    );
    req_ack_window_checker #(.NUM_CH(2), .MIN_LAT(0), .MAX_LAT(0), .CNT_W(3)) u_sat (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .req(r3), .ack(a3),
        .pass_pulse(pp3), .fail_pulse(fp3), .pass_cnt(pc3), .fail_cnt(fc3),
        .vac_cnt(vc3), .err_sticky(es3), .first_fail_ch(ff3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs change at the falling edge; outputs read there reflect the prior rising edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic reset_all();
        rst = 1'b1; en = 1'b1; clr = 1'b0;
        r0 = '0; a0 = '0; r1 = '0; a1 = '0; r2 = '0; a2 = '0; r3 = '0; a3 = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    logic [5:0] t1_req, t1_ack, t1_pass, t1_fail;

    initial begin
        reset_all();
        check("rst_pass_cnt", 32'(pc0), 0);
        check("rst_vac_cnt", 32'(vc0), 0);
        check("rst_err", 32'(es0), 0);
        check("rst_pulses", 32'({pp0, fp0}), 0);

        // Default config, ch0: edges 1..6 (bit i-1 = edge i); ch1 idle adds 6 vacuous.
        t1_req  = 6'b101010;
        t1_ack  = 6'b000010;
        t1_pass = 6'b000010;
        t1_fail = 6'b101000;
        for (int i = 0; i < 6; i++) begin
            r0 = {1'b0, t1_req[i]};
            a0 = {1'b0, t1_ack[i]};
            tick();
            check($sformatf("t1_pass_e%0d", i + 1), 32'(pp0), 32'({1'b0, t1_pass[i]}));
            check($sformatf("t1_fail_e%0d", i + 1), 32'(fp0), 32'({1'b0, t1_fail[i]}));
        end
        check("t1_pass_cnt", 32'(pc0), 1);
        check("t1_fail_cnt", 32'(fc0), 2);
        check("t1_vac_cnt", 32'(vc0), 9);
        check("t1_err", 32'(es0), 1);
        check("t1_ffc", 32'(ff0), 0);

        // Two channels deciding in the same cycle.
        reset_all();
        r0 = 2'b11; a0 = 2'b11; tick();
        check("t4_pp_both", 32'(pp0), 3);
        check("t4_pass_cnt2", 32'(pc0), 2);
        r0 = 2'b11; a0 = 2'b00; tick();
        check("t4_fp_both", 32'(fp0), 3);
        check("t4_fail_cnt2", 32'(fc0), 2);
        check("t4_ffc_low", 32'(ff0), 0);
        check("t4_err", 32'(es0), 1);
        r0 = 2'b00; tick();
        r0 = 2'b11; tick();
        check("t4_ffc_held", 32'(ff0), 0);
        reset_all();
        r0 = 2'b10; a0 = 2'b00; tick();
        check("t4_ffc_ch1", 32'(ff0), 1);
        check("t4_vac_ch0", 32'(vc0), 1);

        // MIN_LAT=1 MAX_LAT=3: ack at offset 2 passes.
        reset_all();
        r1 = 2'b01; a1 = 2'b00; tick();
        r1 = 2'b00; tick();
        check("t2_no_pulse_off1", 32'({pp1, fp1}), 0);
        a1 = 2'b01; tick();
        check("t2_pass_off2", 32'(pp1), 1);
        a1 = 2'b00; tick();
        check("t2_pass_one_cycle", 32'(pp1), 0);
        // No ack through offset 3: fail right after the offset-3 edge.
        r1 = 2'b01; tick();
        r1 = 2'b00; tick();
        tick();
        check("t2_no_fail_off2", 32'(fp1), 0);
        tick();
        check("t2_fail_off3", 32'(fp1), 1);
        a1 = 2'b01; tick();
        check("t2_late_ack_quiet", 32'({pp1, fp1}), 0);
        // Offset-0 ack ignored, offset-2 ack passes.
        r1 = 2'b01; a1 = 2'b01; tick();
        check("t2_off0_ignored", 32'({pp1, fp1}), 0);
        r1 = 2'b00; a1 = 2'b00; tick();
        a1 = 2'b01; tick();
        check("t2_pass_after_off0", 32'(pp1), 1);
        a1 = 2'b00; tick();
        check("t2_pass_cnt", 32'(pc1), 2);
        check("t2_fail_cnt", 32'(fc1), 1);

        // MIN_LAT=2 MAX_LAT=3: early ack fails; req held during WAIT opens nothing.
        reset_all();
        r2 = 2'b01; a2 = 2'b00; tick();
        r2 = 2'b00; a2 = 2'b01; tick();
        check("t3_early_fail", 32'(fp2), 1);
        a2 = 2'b00; r2 = 2'b01; tick();
        tick();
        check("t3_held_req_off1", 32'({pp2, fp2}), 0);
        a2 = 2'b01; tick();
        check("t3_held_req_pass", 32'(pp2), 1);
        r2 = 2'b00; a2 = 2'b00; tick();
        check("t3_after_quiet", 32'({pp2, fp2}), 0);
        check("t3_pass_cnt", 32'(pc2), 1);
        check("t3_fail_cnt", 32'(fc2), 1);

        // CNT_W=3 saturation and clr discarding the same-cycle pass.
        reset_all();
        r3 = 2'b01; a3 = 2'b01;
        repeat (7) tick();
        check("t5_pass_at7", 32'(pc3), 7);
        check("t5_vac_sat", 32'(vc3), 7);
        repeat (2) tick();
        check("t5_pass_sat", 32'(pc3), 7);
        clr = 1'b1; tick();
        check("t5_clr_cnt", 32'(pc3), 0);
        check("t5_clr_pulse_kept", 32'(pp3), 1);
        clr = 1'b0; r3 = 2'b00; a3 = 2'b00; tick();
        check("t5_after_clr_cnt", 32'(pc3), 0);
        check("t5_after_clr_vac", 32'(vc3), 2);

        // Reset mid-WAIT, then a fresh window that fails exactly at offset 3.
        reset_all();
        r1 = 2'b01; a1 = 2'b00; tick();
        r1 = 2'b00; tick();
        rst = 1'b1; tick();
        check("t6_rst_pulses", 32'({pp1, fp1}), 0);
        check("t6_rst_cnts", 32'({pc1, fc1}), 0);
        check("t6_rst_vac", 32'(vc1), 0);
        rst = 1'b0; r1 = 2'b01; tick();
        r1 = 2'b00; tick();
        check("t6_fresh_off1", 32'(fp1), 0);
        tick();
        check("t6_fresh_off2", 32'(fp1), 0);
        tick();
        check("t6_fresh_fail_off3", 32'(fp1), 1);

        // en drop mid-WAIT abandons the window silently.
        reset_all();
        r1 = 2'b01; a1 = 2'b00; tick();
        check("t6_en_vac_before", 32'(vc1), 1);
        en = 1'b0; r1 = 2'b00; a1 = 2'b01; tick();
        check("t6_en_off_pulse", 32'({pp1, fp1}), 0);
        tick();
        check("t6_en_off_pulse2", 32'({pp1, fp1}), 0);
        check("t6_en_off_cnts", 32'({pc1, fc1}), 0);
        check("t6_en_off_vac", 32'(vc1), 1);
        en = 1'b1; a1 = 2'b00; r1 = 2'b01; tick();
        r1 = 2'b00; tick();
        check("t6_reen_off1", 32'({pp1, fp1}), 0);
        a1 = 2'b01; tick();
        check("t6_reen_pass", 32'(pp1), 1);
        a1 = 2'b00; tick();
        check("t6_reen_pass_cnt", 32'(pc1), 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
